// File: rtl/sort_stream_driver.sv
// Stream front-end for the memory-based sorter: loads a frame, starts the sort, then streams the result back.
// Optional build macro SORT_TIMEOUT_EN adds a watchdog on the wait for done (timeout_err pulse, frame dropped).
module sort_stream_driver #(
    parameter int N           = 8,
    parameter int L           = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic         timeout_err,
    output logic         srt_s,
    input  logic         srt_done,
    output logic         srt_rd,
    output logic         srt_wrinit,
    output logic [N-1:0] srt_datain,
    output logic [L-1:0] srt_radd,
    input  logic [N-1:0] srt_dataout
);

    localparam logic [L-1:0] LAST_ADDR = {L{1'b1}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RDREQ = 3'd4;
    localparam logic [2:0] S_RDCAP = 3'd5;
    localparam logic [2:0] S_EMIT  = 3'd6;

    logic [2:0]   r_state;
    logic [L-1:0] r_cnt;
    logic         r_srt_s;
    logic         r_srt_wrinit;
    logic [N-1:0] r_srt_datain;
    logic [L-1:0] r_srt_radd;
    logic         r_out_valid;
    logic [N-1:0] r_out_data;
    logic         r_out_last;

    logic w_cnt_last;
    logic w_timeout;

    assign w_cnt_last = (r_cnt == LAST_ADDR);

`ifdef SORT_TIMEOUT_EN
    localparam int WC_W = $clog2(TIMEOUT_CYC + 1);

    logic [WC_W-1:0] r_wait_cnt;
    logic            r_timeout_err;

    // done takes priority over expiry when both land in the same cycle
    assign w_timeout = (r_state == S_WAIT) && !srt_done &&
                       (r_wait_cnt == WC_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if (r_state == S_START) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (TIMEOUT_CYC > 0);
    assign w_timeout    = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_srt_s      <= 1'b0;
            r_srt_wrinit <= 1'b0;
            r_srt_datain <= '0;
            r_srt_radd   <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
        end else begin
            r_srt_wrinit <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        r_srt_wrinit <= 1'b1;
                        r_srt_datain <= in_data;
                        r_srt_radd   <= r_cnt;
                        if (w_cnt_last) begin
                            r_state <= S_START;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_START: begin
                    // the final write lands on this edge, so start is seen one edge later
                    r_srt_s <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (srt_done) begin
                        r_srt_s    <= 1'b0;
                        r_srt_radd <= r_cnt;
                        r_state    <= S_RDREQ;
                    end else if (w_timeout) begin
                        r_srt_s <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RDREQ: begin
                    r_state <= S_RDCAP;
                end
                S_RDCAP: begin
                    r_out_data  <= srt_dataout;
                    r_out_valid <= 1'b1;
                    r_out_last  <= w_cnt_last;
                    r_state     <= S_EMIT;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (w_cnt_last) begin
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt      <= r_cnt + 1'b1;
                            r_srt_radd <= r_cnt + 1'b1;
                            r_state    <= S_RDREQ;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (r_state == S_LOAD);
    assign busy       = (r_state != S_IDLE);
    assign srt_rd     = (r_state == S_RDREQ);
    assign srt_s      = r_srt_s;
    assign srt_wrinit = r_srt_wrinit;
    assign srt_datain = r_srt_datain;
    assign srt_radd   = r_srt_radd;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;

endmodule
